// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types, including multiply/divide opcodes and states
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int MD_ITER = 32;

endpackage

`default_nettype wire

// File: rtl/md_datapath.sv
// ============================================================================
// Module      : md_datapath
// Description : Unsigned shift-add multiply / restoring divide, one bit per step
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_datapath
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nrst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [63:0] r_acc;
    word_t       r_b;
    word_t       r_quot;
    word_t       r_rem;

    logic [32:0] w_sum;
    logic [32:0] w_trial;
    logic        w_fits;
    word_t       w_diff;

    // Multiply and divide advance together; only the one matching the op is used.
    always_comb begin
        w_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : '0)};
        w_trial = {r_rem, r_quot[31]};
        w_fits  = (w_trial >= {1'b0, r_b});
        w_diff  = {r_rem[30:0], r_quot[31]} - r_b;
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
        end else if (load) begin
            r_acc  <= {32'd0, a_mag};
            r_b    <= b_mag;
            r_quot <= a_mag;
            r_rem  <= '0;
        end else if (step) begin
            r_acc  <= {w_sum, r_acc[31:1]};
            r_quot <= {r_quot[30:0], w_fits};
            r_rem  <= w_fits ? w_diff : {r_rem[30:0], r_quot[31]};
        end
    end

    assign prod = r_acc;
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/DIV unit with architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic              flush,
    input  logic [WORD_W-1:0] rs,
    input  logic [WORD_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam logic [4:0] C_LAST = 5'(MD_ITER - 1);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_done;
    word_t       r_hi;
    word_t       r_lo;

    logic        w_accept;
    logic        w_op_md;
    logic        w_op_div;
    logic        w_signed;
    logic        w_div0;
    logic        w_a_neg;
    logic        w_b_neg;
    word_t       w_a_mag;
    word_t       w_b_mag;
    logic        w_load;
    logic        w_step;
    logic        w_wr;
    logic [63:0] w_prod;
    word_t       w_quot;
    word_t       w_rem;
    logic [63:0] w_prod_fix;
    word_t       w_quot_fix;
    word_t       w_rem_fix;

    always_comb begin
        w_accept = start && !flush && (r_state == IDLE);
        w_op_md  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        w_op_div = (op == MD_DIV) || (op == MD_DIVU);
        w_signed = (op == MD_MULT) || (op == MD_DIV);
        w_div0   = w_op_div && (rt == '0);
        w_a_neg  = w_signed && rs[31];
        w_b_neg  = w_signed && rt[31];
        // A zero divisor leaves the raw dividend in the remainder, so feed rs unmodified.
        w_a_mag  = (w_a_neg && !w_div0) ? -rs : rs;
        w_b_mag  = w_b_neg ? -rt : rt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_wr        = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_op_md) begin
                        w_load      = 1'b1;
                        w_state_nxt = CALC;
                    end
                end
                CALC: begin
                    w_step = 1'b1;
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = FIX;
                    end
                end
                FIX: begin
                    w_wr        = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_wr;
            if (w_load) begin
                r_cnt     <= '0;
                r_is_div  <= w_op_div;
                r_neg_res <= !w_div0 && (w_a_neg ^ w_b_neg);
                r_neg_rem <= !w_div0 && w_op_div && w_a_neg;
            end else if (w_step) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    md_datapath u_datapath (
        .CLK   (CLK),
        .nrst  (nrst),
        .load  (w_load),
        .step  (w_step),
        .a_mag (w_a_mag),
        .b_mag (w_b_mag),
        .prod  (w_prod),
        .quot  (w_quot),
        .rem   (w_rem)
    );

    always_comb begin
        w_prod_fix = r_neg_res ? -w_prod : w_prod;
        w_quot_fix = r_neg_res ? -w_quot : w_quot;
        w_rem_fix  = r_neg_rem ? -w_rem  : w_rem;
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_wr) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quot_fix;
            end else begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
            end
        end else if (w_accept && (op == MD_MTHI)) begin
            r_hi <= rs;
        end else if (w_accept && (op == MD_MTLO)) begin
            r_lo <= rs;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        nrst;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_pass;
    int          n_total;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.WORD_W(32)) dut (
        .CLK   (CLK),
        .nrst  (nrst),
        .start (start),
        .op    (op),
        .flush (flush),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Architectural result {hi,lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = {m_hi, m_lo};
        endcase
        return p;
    endfunction

    // Issue in cycle 0, spam ignored MTHI starts while busy, check cycle 34.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int bad;
        exp   = model(o, a, b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        bad   = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
            start = 1'b1;
            op    = 3'd4;
            rs    = $urandom;
            rt    = $urandom;
        end
        tick();
        start = 1'b0;
        check({tag, "_busy_window"}, 64'(bad), 64'd0);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_done_busy"}, {62'd0, done, busy}, 64'b10);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1;
        op    = o;
        rs    = v;
        tick();
        start = 1'b0;
        if (o == 3'd4) m_hi = v;
        else m_lo = v;
        check("mt_hilo", {hi, lo}, {m_hi, m_lo});
        check("mt_busy_done", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int bad;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        n_pass  = 0;
        n_total = 0;
        m_hi    = '0;
        m_lo    = '0;
        nrst    = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 3'd0;
        rs      = '0;
        rt      = '0;
        #2;
        check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();

        run_op("mult_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
        run_op("divu_by0", 3'd3, 32'h0000_1234, 32'd0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_by0_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
        tick();
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // MTHI/MTLO then a MULT flushed mid-CALC with an MTLO start held throughout.
        mt(3'd4, 32'hA5A5_A5A5);
        mt(3'd5, 32'h1357_9BDF);
        start = 1'b1;
        op    = 3'd0;
        rs    = $urandom;
        rt    = $urandom;
        bad   = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            op = 3'd5;
            rs = $urandom;
            if (k == 10) flush = 1'b1;
        end
        tick();
        flush = 1'b0;
        start = 1'b0;
        check("flush_calc_busy_window", 64'(bad), 64'd0);
        check("flush_calc_idle", {62'd0, busy, done}, 64'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) bad++;
        end
        check("flush_calc_no_done", 64'(bad), 64'd0);
        check("flush_calc_hilo", {hi, lo}, {64'hA5A5_A5A5_1357_9BDF});

        // Flush landing on the FIX cycle suppresses the write.
        start = 1'b1;
        op    = 3'd3;
        rs    = 32'd1000;
        rt    = 32'd3;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 33; k++) tick();
        check("fix_cycle_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fix_done", {62'd0, busy, done}, 64'd0);
        check("flush_fix_hilo", {hi, lo}, {m_hi, m_lo});

        // Flush beats a simultaneous MTHI; a reserved op does nothing.
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'hDEAD_BEEF;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        check("flush_mthi_hi", {32'd0, hi}, {32'd0, m_hi});
        start = 1'b1;
        op    = 3'd6;
        rs    = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        check("reserved_busy", {63'd0, busy}, 64'd0);
        tick();
        check("reserved_hilo_done", {31'd0, done, hi, lo} >> 0, {31'd0, 1'b0, m_hi, m_lo});

        // Asynchronous reset in cycle 20 of a DIV.
        start = 1'b1;
        op    = 3'd2;
        rs    = 32'h8765_4321;
        rt    = 32'd13;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 20; k++) tick();
        #2;
        nrst = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("midop_reset", {30'd0, busy, done, hi}, 64'd0);
        check("midop_reset_lo", {32'd0, lo}, 64'd0);
        tick();
        nrst = 1'b1;
        tick();
        run_op("after_reset_div", 3'd2, 32'h8765_4321, 32'd13);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("random", ro, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
